// File: rtl/b_demux2_tdm.sv
// Two-channel TDM demultiplexer: rebuilds ch0/ch1 from an interleaved stream with sync tracking.
// Optional sync-violation counter enabled by defining B_DEMUX2_TDM_ERRCNT_EN.
module b_demux2_tdm #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    input  logic         dv,
    input  logic         sync,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic         yv,
    output logic         locked,
    output logic         err,
    output logic [7:0]   fcnt,
    output logic [7:0]   ecnt
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        WAIT1 = 2'd1,
        WAIT0 = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_h;
    logic [W-1:0]       w_h_nxt;
    logic [W-1:0]       r_y0;
    logic [W-1:0]       w_y0_nxt;
    logic [W-1:0]       r_y1;
    logic [W-1:0]       w_y1_nxt;
    logic               r_yv;
    logic               w_yv_nxt;
    logic               r_locked;
    logic               w_locked_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic [CNT_W-1:0]   r_fcnt;
    logic [CNT_W-1:0]   w_fcnt_nxt;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= HUNT;
            r_h      <= '0;
            r_y0     <= '0;
            r_y1     <= '0;
            r_yv     <= 1'b0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_fcnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_h      <= w_h_nxt;
            r_y0     <= w_y0_nxt;
            r_y1     <= w_y1_nxt;
            r_yv     <= w_yv_nxt;
            r_locked <= w_locked_nxt;
            r_err    <= w_err_nxt;
            r_fcnt   <= w_fcnt_nxt;
        end
    end

    // Frame alignment: only accepted words (dv=1) advance the machine
    always_comb begin
        w_state_nxt  = r_state;
        w_h_nxt      = r_h;
        w_y0_nxt     = r_y0;
        w_y1_nxt     = r_y1;
        w_yv_nxt     = 1'b0;
        w_locked_nxt = r_locked;
        w_err_nxt    = 1'b0;
        w_fcnt_nxt   = r_fcnt;
        if (dv) begin
            case (r_state)
                HUNT: begin
                    if (sync) begin
                        w_h_nxt     = d;
                        w_state_nxt = WAIT1;
                    end
                end
                WAIT1: begin
                    if (sync) begin
                        // Repeated sync restarts the frame on the newer ch0 word
                        w_err_nxt = 1'b1;
                        w_h_nxt   = d;
                    end else begin
                        w_y0_nxt     = r_h;
                        w_y1_nxt     = d;
                        w_yv_nxt     = 1'b1;
                        w_fcnt_nxt   = r_fcnt + CNT_W'(1);
                        w_locked_nxt = 1'b1;
                        w_state_nxt  = WAIT0;
                    end
                end
                WAIT0: begin
                    if (sync) begin
                        w_h_nxt     = d;
                        w_state_nxt = WAIT1;
                    end else begin
                        w_err_nxt    = 1'b1;
                        w_locked_nxt = 1'b0;
                        w_state_nxt  = HUNT;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

`ifdef B_DEMUX2_TDM_ERRCNT_EN
    logic [CNT_W-1:0] r_ecnt;

    // Saturating violation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ecnt <= '0;
        end else if (w_err_nxt && (r_ecnt != {CNT_W{1'b1}})) begin
            r_ecnt <= r_ecnt + CNT_W'(1);
        end
    end

    assign ecnt = r_ecnt;
`else
    assign ecnt = '0;
`endif

    assign y0     = r_y0;
    assign y1     = r_y1;
    assign yv     = r_yv;
    assign locked = r_locked;
    assign err    = r_err;
    assign fcnt   = r_fcnt;

endmodule

// File: doc/b_demux2_tdm.md
# b_demux2_tdm

Two-channel time-division demultiplexer: takes a single word stream in which channel 0 and channel 1 alternate, flagged by a slot-0 sync marker, and rebuilds the two channels as parallel registered outputs. It is the receive-side counterpart of the 2:1 select path (b_mux2 family) and sits behind any link that interleaves two channels onto one bus. Frame alignment is tracked by a small state machine with loss-of-sync detection and resynchronisation.

## Interface
- W, 8, data word width (1..32)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- d  in  W  interleaved input word
- dv  in  1  d is valid this cycle
- sync  in  1  qualifies d as the channel-0 word (meaningful only with dv)
- y0  out  W  channel-0 word of last complete frame
- y1  out  W  channel-1 word of last complete frame
- yv  out  1  one-cycle pulse: y0/y1 updated
- locked  out  1  frame alignment held
- err  out  1  one-cycle pulse: sync violation
- fcnt  out  8  completed-frame counter, wraps 255->0
- ecnt  out  8  sync-violation counter, saturates at 255 (see Configuration)

## Operation
- Reset values: y0=0, y1=0, yv=0, locked=0, err=0, fcnt=0, ecnt=0, internal hold register h=0, state HUNT.
- A word is accepted on a rising edge where dv=1; dv=0 cycles are ignored in every state (no timeout).
- States:
  - HUNT: dv&sync -> h<=d, go WAIT1. dv&!sync -> word dropped, stay, no err.
  - WAIT1 (expect ch1): dv&!sync -> y0<=h, y1<=d, yv pulse, fcnt+1, locked<=1, go WAIT0. dv&sync -> err pulse, h<=d (treat as new ch0), stay WAIT1; y0/y1 unchanged.
  - WAIT0 (expect ch0): dv&sync -> h<=d, go WAIT1. dv&!sync -> err pulse, locked<=0, word dropped, go HUNT.
- locked is set only by a completed frame and cleared only by a WAIT0 violation or reset; a WAIT1 violation does not clear it.
- y0/y1 change only together, only with yv; they hold between frames.
- fcnt increments by exactly 1 per yv, modulo 256.
- sync with dv=0 has no effect.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Latency: yv, y0, y1, fcnt update in the cycle following the edge that samples the ch1 word (1 clock).
- err asserts in the cycle following the violating word's sample edge, for exactly one cycle.
- Back-to-back frames with dv held high give yv on every second cycle.
- rst asserted mid-frame: all outputs and state return to reset values immediately, without waiting for clk; a partially captured ch0 word is discarded. First accepted word after rst deassertion is evaluated in HUNT.

## Configuration
- B_DEMUX2_TDM_ERRCNT_EN defined: ecnt increments on every err pulse, saturating at 255; cleared only by rst.
- Undefined: no counter logic; ecnt tied to 0. err, locked and all other behaviour are identical.

## Test plan
- Reset: rst high mid-run -> all outputs 0, state HUNT; after release, d=0x11 dv=1 sync=0 -> dropped, no err, yv stays 0.
- Normal frame: (0xA5,sync=1),(0x3C,sync=0) on consecutive cycles -> next cycle y0=0xA5, y1=0x3C, yv=1 for one cycle, locked=1, fcnt=1.
- Gapped input: same frame with 3 dv=0 cycles between words and sync toggling while dv=0 -> identical result to normal frame.
- WAIT1 violation: (0x01,sync=1),(0x02,sync=1),(0x03,sync=0) -> err pulse after 2nd word, then y0=0x02, y1=0x03, yv=1; locked unchanged.
- WAIT0 violation after lock: complete frame, then (0x77,sync=0) -> err pulse, locked=0, y0/y1 hold; next (0x10,1),(0x20,0) -> relocks, y0=0x10, y1=0x20.
- Wrap/saturation: 256 frames -> fcnt back to 0; with B_DEMUX2_TDM_ERRCNT_EN, 300 violations -> ecnt=255; without the macro, ecnt=0 throughout.
